// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared FSM encoding and default sizing for the PWM capture block.
package pwm_capture_pkg;
    typedef enum logic [1:0] {S_WAIT, S_MEAS, S_DIV} state_t;
    localparam int          CNT_W_DEF   = 16;
    localparam logic [15:0] TIMEOUT_DEF = 16'hFFFF;
endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM input and measurement result bundle.
interface pwm_capture_if import pwm_capture_pkg::*; #(
    parameter int P_CNT_W = CNT_W_DEF
);
    logic               i_pwm;
    logic [7:0]         o_duty;
    logic [P_CNT_W-1:0] o_period;
    logic               o_valid;
    logic               o_timeout;
    modport master (output i_pwm, input o_duty, o_period, o_valid, o_timeout);
    modport slave  (input i_pwm, output o_duty, o_period, o_valid, o_timeout);
endinterface

// File: rtl/pwm_capture_div.sv
// pwm_div: 8-step restoring division of num*256 by den, clamped to 255 when num >= den.
module pwm_div import pwm_capture_pkg::*; #(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic         busy,
    output logic         done,
    output logic [7:0]   q
);
    logic [W-1:0] rem, div;
    logic [W:0]   diff;
    logic [7:0]   quo;
    logic [3:0]   left;
    logic         clamp, ge;
    // rem < div keeps 2*rem - div in range, so the top bit is a clean borrow flag
    assign diff = {rem, 1'b0} - {1'b0, div};
    assign ge   = ~diff[W];
    assign q    = clamp ? 8'hFF : quo;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem   <= '0;
            div   <= '0;
            quo   <= '0;
            left  <= '0;
            clamp <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            rem   <= num;
            div   <= den;
            quo   <= '0;
            left  <= 4'd8;
            clamp <= num >= den;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (busy) begin
            rem  <= ge ? diff[W-1:0] : {rem[W-2:0], 1'b0};
            quo  <= {quo[6:0], ge};
            left <= left - 4'd1;
            busy <= left != 4'd1;
            done <= left == 4'd1;
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and duty of an asynchronous PWM input between rising edges.
module pwm_capture import pwm_capture_pkg::*; #(
    parameter int                 P_CNT_W   = CNT_W_DEF,
    parameter logic [P_CNT_W-1:0] P_TIMEOUT = P_CNT_W'(TIMEOUT_DEF)
) (
    input logic          i_clk,
    input logic          i_rst_n,
    pwm_capture_if.slave bus
);
    state_t             state, state_n;
    logic [2:0]         sync_q;
    logic               sync, rise, hit;
    logic [P_CNT_W-1:0] per_cnt, high_cnt, per_cap;
    logic               restart, start, publish, tmo;
    logic               div_busy, div_done;
    logic [7:0]         div_q;

    function automatic logic [P_CNT_W-1:0] sat_inc(input logic [P_CNT_W-1:0] v);
        return &v ? v : v + P_CNT_W'(1);
    endfunction

    // sync_q: {history, synchronized, metastable}
    assign sync = sync_q[1];
    assign rise = sync_q[1] & ~sync_q[2];
    assign hit  = per_cnt >= P_TIMEOUT;

    always_ff @(posedge i_clk)
        state <= !i_rst_n ? S_WAIT : state_n;

    // a rise during S_DIV only restarts the counters; the running division still completes
    always_comb begin
        state_n = state;
        restart = 1'b0;
        start   = 1'b0;
        publish = 1'b0;
        tmo     = 1'b0;
        case (state)
            S_WAIT: begin
                restart = rise;
                state_n = rise ? S_MEAS : S_WAIT;
            end
            S_MEAS: begin
                restart = rise;
                start   = rise;
                tmo     = !rise && hit;
                state_n = rise ? S_DIV : hit ? S_WAIT : S_MEAS;
            end
            S_DIV: begin
                restart = rise;
                publish = !div_busy && div_done;
                state_n = div_busy ? S_DIV : S_MEAS;
            end
            default: state_n = S_WAIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q        <= '0;
            per_cnt       <= '0;
            high_cnt      <= '0;
            per_cap       <= '0;
            bus.o_duty    <= '0;
            bus.o_period  <= '0;
            bus.o_valid   <= 1'b0;
            bus.o_timeout <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], bus.i_pwm};
            per_cnt  <= restart ? P_CNT_W'(1) : state == S_WAIT ? per_cnt : sat_inc(per_cnt);
            high_cnt <= restart ? P_CNT_W'(1) : (state == S_WAIT || !sync) ? high_cnt : sat_inc(high_cnt);
            if (start) per_cap <= per_cnt;
            bus.o_valid <= publish | tmo;
            if (publish) begin
                bus.o_duty   <= div_q;
                bus.o_period <= per_cap;
            end
            if (tmo) begin
                bus.o_duty   <= sync ? 8'hFF : 8'h00;
                bus.o_period <= '0;
            end
            if (tmo || (state == S_WAIT && rise)) bus.o_timeout <= tmo;
        end
    end

    pwm_div #(.W(P_CNT_W)) u_div (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .start (start),
        .num   (high_cnt),
        .den   (per_cnt),
        .busy  (div_busy),
        .done  (div_done),
        .q     (div_q)
    );
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM patterns checked every cycle against an edge-timestamp model,
// plus literal expectations for the headline cases.
module tb_pwm_capture;
    localparam int TMO = 65535;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    pwm_capture_if #(.P_CNT_W(16)) bus ();

    pwm_capture dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // model state: timestamps of rise detections and scheduled output events
    logic [3:0] h     = '0;
    logic       rst_q = 1'b1;
    logic       live  = 1'b0;
    logic       acq   = 1'b0;
    int ref_c, last_cap, pend, to_at, clr_at, hsum, pd_duty, pd_per, to_duty;
    int e_duty, e_per;
    logic e_val, e_to;
    int vcount = 0;
    int last_duty, last_per, last_vcyc;

    always @(negedge clk) begin
        logic s, r;
        h = {h[2:0], bus.i_pwm};
        if (!rst_q) h[3:1] = 3'b000;
        s = h[2];
        r = h[2] & ~h[3];
        if (!rst_q) begin
            live = 1'b1; acq = 1'b0;
            pend = -1; to_at = -1; clr_at = -1; last_cap = -100; hsum = 0; ref_c = 0;
            e_val = 1'b0; e_duty = 0; e_per = 0; e_to = 1'b0;
        end else if (live) begin
            e_val = 1'b0;
            if (cyc == pend) begin e_val = 1'b1; e_duty = pd_duty; e_per = pd_per; end
            if (cyc == to_at) begin e_val = 1'b1; e_duty = to_duty; e_per = 0; e_to = 1'b1; end
            if (cyc == clr_at) e_to = 1'b0;
            if (r) begin
                if (!acq) begin
                    acq = 1'b1;
                    clr_at = cyc + 1;
                end else if (cyc > last_cap + 9) begin
                    pd_per   = cyc - ref_c;
                    pd_duty  = (hsum >= pd_per) ? 255 : (hsum * 256) / pd_per;
                    pend     = cyc + 10;
                    last_cap = cyc;
                end
                ref_c = cyc;
                hsum  = 0;
            end else if (acq && cyc - ref_c >= TMO) begin
                to_at   = cyc + 1;
                to_duty = s ? 255 : 0;
                acq     = 1'b0;
            end
            hsum += int'(s);
        end
        if (live) begin
            chk("valid",   int'(bus.o_valid),   int'(e_val));
            chk("duty",    int'(bus.o_duty),    e_duty);
            chk("period",  int'(bus.o_period),  e_per);
            chk("timeout", int'(bus.o_timeout), int'(e_to));
        end
        if (bus.o_valid === 1'b1) begin
            vcount++;
            last_duty = int'(bus.o_duty);
            last_per  = int'(bus.o_period);
            last_vcyc = cyc;
        end
        rst_q = rst_n;
    end

    task automatic hold(input logic v, input int n);
        bus.i_pwm = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic periods(input int per, input int hi, input int k);
        for (int i = 0; i < k; i++) begin
            hold(1'b1, hi);
            hold(1'b0, per - hi);
        end
    endtask

    initial begin
        int v0, t0;
        bus.i_pwm = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_duty",    int'(bus.o_duty),    0);
        chk("rst_period",  int'(bus.o_period),  0);
        chk("rst_valid",   int'(bus.o_valid),   0);
        chk("rst_timeout", int'(bus.o_timeout), 0);
        hold(1'b0, 5);

        v0 = vcount; t0 = cyc;
        periods(128, 32, 2);
        chk("p128h32_count",   vcount - v0, 1);
        chk("p128h32_duty",    last_duty, 64);
        chk("p128h32_period",  last_per, 128);
        chk("p128h32_latency", last_vcyc - (t0 + 128), 12);

        periods(128, 127, 2);
        chk("p128h127_duty",   last_duty, 254);
        chk("p128h127_period", last_per, 128);

        periods(128, 1, 2);
        chk("p128h1_duty", last_duty, 2);

        periods(1000, 500, 2);
        chk("p1000_duty",   last_duty, 128);
        chk("p1000_period", last_per, 1000);

        v0 = vcount;
        periods(8, 2, 6);
        chk("p8_count",  vcount - v0, 3);
        chk("p8_duty",   last_duty, 64);
        chk("p8_period", last_per, 8);

        v0 = vcount;
        hold(1'b1, 70000);
        hold(1'b0, 10);
        chk("tmo_count",   vcount - v0, 2);
        chk("tmo_duty",    last_duty, 255);
        chk("tmo_period",  last_per, 0);
        chk("tmo_flag",    int'(bus.o_timeout), 1);
        v0 = vcount;
        hold(1'b1, 5);
        hold(1'b0, 5);
        chk("tmo_clear",       int'(bus.o_timeout), 0);
        chk("tmo_clear_count", vcount - v0, 0);

        v0 = vcount;
        hold(1'b1, 2);
        hold(1'b0, 3);
        rst_n = 1'b0;
        hold(1'b0, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_duty",    int'(bus.o_duty),    0);
        chk("mid_rst_period",  int'(bus.o_period),  0);
        chk("mid_rst_valid",   int'(bus.o_valid),   0);
        chk("mid_rst_timeout", int'(bus.o_timeout), 0);
        @(posedge clk);
        #1;
        periods(100, 30, 1);
        chk("mid_rst_quiet", vcount - v0, 0);
        periods(100, 30, 1);
        chk("mid_rst_count",  vcount - v0, 1);
        chk("mid_rst_duty2",  last_duty, 76);
        chk("mid_rst_period2", last_per, 100);

        hold(1'b0, 20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter P_CNT_W, default 16, width of period/high counters and o_period.
REQ-002 SHALL have parameter P_TIMEOUT, default 16'hFFFF, cycles without rising edge before timeout.
REQ-003 SHALL have port i_clk  input  1  single system clock (40 MHz); all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_pwm  input  1  asynchronous PWM waveform to be measured.
REQ-006 SHALL have port o_duty  output  8  measured duty, floor(high*256/period).
REQ-007 SHALL have port o_period  output  P_CNT_W  measured period in i_clk cycles.
REQ-008 SHALL have port o_valid  output  1  one-cycle pulse when o_duty/o_period update.
REQ-009 SHALL have port o_timeout  output  1  level; no rising edge within P_TIMEOUT cycles.

Function
REQ-010 SHALL pass i_pwm through a 2-flop synchronizer plus one history flop; rise = sync&~hist, fall = ~sync&hist.
REQ-011 SHALL implement states S_WAIT (no reference edge yet), S_MEAS (counting), S_DIV (duty division).
REQ-012 SHALL leave S_WAIT on the first rise, clearing period counter to 1 and high counter to 1.
REQ-013 SHALL, in S_MEAS/S_DIV, increment period counter every cycle and high counter every cycle with sync=1, both saturating.
REQ-014 SHALL, on a rise in S_MEAS, capture period = counter value (cycles between consecutive rise detections) and high count, restart both counters at 1, enter S_DIV.
REQ-015 SHALL compute duty via 8-iteration restoring division of high*256 by period; quotient fits 8 bits since high < period.
REQ-016 SHALL clamp duty to 8'd255 if captured high >= period.
REQ-017 SHALL register o_duty, o_period and pulse o_valid exactly 10 cycles after the capturing rise-detect cycle (1 load, 8 iterations, 1 output).
REQ-018 SHALL keep measuring during S_DIV; a rise while S_DIV busy discards that period's sample (no o_valid) but restarts counters.
REQ-019 SHALL, when period counter reaches P_TIMEOUT, set o_duty = 8'd255 if sync=1 else 8'd0, o_period = 0, pulse o_valid once, set o_timeout, enter S_WAIT.
REQ-020 SHALL clear o_timeout on the next rise detect; no o_valid for that edge (re-acquire).
REQ-021 SHALL hold o_duty/o_period stable between o_valid pulses.

Reset
REQ-022 SHALL, while i_rst_n=0 at a clock edge, set o_duty=0, o_period=0, o_valid=0, o_timeout=0, synchronizer flops=0, counters=0, state S_WAIT.
REQ-023 SHALL abort any in-progress division on reset with no o_valid emitted afterward for it.

Structure
REQ-024 SHALL place state encoding and default P_CNT_W/P_TIMEOUT in the shared project package.
REQ-025 SHALL implement the restoring divider as sub-module pwm_div (start, busy, done, 8-bit quotient).

Verification
REQ-026 SHALL test period 128, high 32 cycles -> o_period=128, o_duty=64, o_valid 10 cycles after rise detect.
REQ-027 SHALL test period 128, high 127 -> o_duty=254; high 1 -> o_duty=2.
REQ-028 SHALL test i_pwm held 1 for 70000 cycles -> o_duty=255, o_period=0, o_timeout=1, single o_valid; next rise clears o_timeout.
REQ-029 SHALL test period 8 cycles back-to-back -> alternate samples dropped, no corrupted o_duty.
REQ-030 SHALL test i_rst_n=0 for 1 cycle mid-S_DIV -> all outputs 0, no o_valid until two full new periods.
REQ-031 SHALL test period 1000, high 500 -> o_duty=128, o_period=1000.
